// File: rtl/spu_integrate_if.sv
// spu_integrate_if
//   Stream bundle for the SPU running-sum integrator.
//   Input side:  s_valid, s_clear, s_data (signed increment, S_DATA_BITS)
//   Output side: m_valid, m_data (signed running sum, M_DATA_BITS), m_sat
//   Modports: slave  - the integrator (consumes s_*, drives m_*)
//             master - the upstream source / downstream sink
interface spu_integrate_if #(
    parameter int S_DATA_BITS = 8,
    parameter int M_DATA_BITS = 8
) ();
    logic                   s_valid;
    logic                   s_clear;
    logic [S_DATA_BITS-1:0] s_data;
    logic                   m_valid;
    logic [M_DATA_BITS-1:0] m_data;
    logic                   m_sat;

    modport slave  (input  s_valid, s_clear, s_data, output m_valid, m_data, m_sat);
    modport master (output s_valid, s_clear, s_data, input  m_valid, m_data, m_sat);
endinterface

// File: rtl/spu_integrate.sv
// spu_integrate
//   Running-sum accumulator that rebuilds x[n] from a difference stream
//   d[n] = x[n]-x[n-1]. s_clear restarts the sum (loading s_data when valid).
//   Stage 1 is the accumulator; LATENCY-1 further stages delay {acc, valid, sat}.
//   Every register advances only when cke=1.
// Ports
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset, flushes acc and all stages
//   cke      clock enable, low = all state holds
//   io       spu_integrate_if.slave: s_valid/s_clear/s_data in,
//            m_valid/m_data/m_sat out
// Configuration
//   SPU_INTEGRATE_SAT_EN  defined: add clamps on overflow and m_sat flags it.
//                         undefined: modulo wrap, m_sat tied to 0.
module spu_integrate #(
    parameter int LATENCY     = 1,
    parameter int S_DATA_BITS = 8,
    parameter int M_DATA_BITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cke,
    spu_integrate_if.slave   io
);
    localparam int M = M_DATA_BITS;
    localparam int W = M + 2;   // {data, valid, sat}

    logic signed [M-1:0] inc;
    logic signed [M-1:0] acc_q, acc_d;
    logic                v1_q;
    logic                sat1;

    assign inc = M'(signed'(io.s_data));

`ifdef SPU_INTEGRATE_SAT_EN
    // One guard bit: overflow when the two top bits of the wide sum disagree.
    logic signed [M:0] wide;
    logic              ovf;
    logic              sat_d, sat1_q;
    assign wide = {acc_q[M-1], acc_q} + {inc[M-1], inc};
    assign ovf  = wide[M] ^ wide[M-1];
`endif

    always_comb begin
        acc_d = acc_q;
`ifdef SPU_INTEGRATE_SAT_EN
        sat_d = 1'b0;
`endif
        if (io.s_clear) begin
            acc_d = io.s_valid ? inc : '0;   // clear loads never saturate
        end else if (io.s_valid) begin
`ifdef SPU_INTEGRATE_SAT_EN
            if (ovf) begin
                acc_d = wide[M] ? {1'b1, {(M-1){1'b0}}} : {1'b0, {(M-1){1'b1}}};
                sat_d = 1'b1;
            end else begin
                acc_d = wide[M-1:0];
            end
`else
            acc_d = acc_q + inc;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
            v1_q  <= 1'b0;
        end else if (cke) begin
            acc_q <= acc_d;
            v1_q  <= io.s_valid;
        end
    end

`ifdef SPU_INTEGRATE_SAT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  sat1_q <= 1'b0;
        else if (cke)  sat1_q <= sat_d;
    end
    assign sat1 = sat1_q;
`else
    assign sat1 = 1'b0;
`endif

    logic [W-1:0] st1;
    assign st1 = {acc_q, v1_q, sat1};

    generate
        if (LATENCY <= 1) begin : g_direct
            assign {io.m_data, io.m_valid, io.m_sat} = st1;
        end else begin : g_delay
            logic [LATENCY-2:0][W-1:0] dly_q;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dly_q <= '0;
                end else if (cke) begin
                    dly_q[0] <= st1;
                    for (int i = 1; i < LATENCY-1; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign {io.m_data, io.m_valid, io.m_sat} = dly_q[LATENCY-2];
        end
    endgenerate
endmodule

// File: tb/tb_spu_integrate.sv
// tb_spu_integrate
//   Scoreboard bench for spu_integrate at LATENCY=3, 8-bit in/out.
//   Expected sums are constants queued when a sample is driven and popped
//   when m_valid appears after an enabled edge; latency is checked in
//   enabled edges. Honour SPU_INTEGRATE_SAT_EN for the overflow expectations.
module tb_spu_integrate;
    localparam int LATENCY = 3;
`ifdef SPU_INTEGRATE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cke = 1'b1;
    always #5 clk = ~clk;

    spu_integrate_if #(.S_DATA_BITS(8), .M_DATA_BITS(8)) bus ();

    spu_integrate #(.LATENCY(LATENCY), .S_DATA_BITS(8), .M_DATA_BITS(8)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .cke     (cke),
        .io      (bus)
    );

    typedef struct {
        logic [7:0] d;
        logic       s;
        int         e;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad = 0;
    int   edge_cnt = 0;
    bit   cke_edge = 1'b0;

    task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cke_edge = cke && rst_n;
        if (cke && rst_n) edge_cnt++;
    end

    always @(negedge clk) begin
        if (rst_n && cke_edge && bus.m_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("data", $signed(bus.m_data), $signed(mon_e.d));
                chk("sat", {31'd0, bus.m_sat}, {31'd0, mon_e.s});
                chk("lat", edge_cnt - mon_e.e, LATENCY-1);
            end
        end
    end

    task automatic send(bit v, bit c, int d, int ed, bit es);
        @(negedge clk);
        cke = 1'b1;
        bus.s_valid = v;
        bus.s_clear = c;
        bus.s_data  = d[7:0];
        if (v) q.push_back('{d: ed[7:0], s: es, e: edge_cnt + 1});
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) send(1'b0, 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        #1;
        chk("drain", q.size(), 0);
    endtask

    task automatic rand_in();
        bus.s_valid = 1'($urandom);
        bus.s_clear = 1'($urandom);
        bus.s_data  = 8'($urandom);
    endtask

    logic       snap_v, snap_s;
    logic [7:0] snap_d;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held with random inputs
        bus.s_valid = 1'b0; bus.s_clear = 1'b0; bus.s_data = '0;
        repeat (6) begin
            @(negedge clk);
            rand_in();
            #1;
            chk("rst_v", {31'd0, bus.m_valid}, 0);
            chk("rst_d", {24'd0, bus.m_data}, 0);
            chk("rst_s", {31'd0, bus.m_sat}, 0);
        end
        @(negedge clk);
        bus.s_valid = 1'b0; bus.s_clear = 1'b0;
        rst_n = 1'b1;
        send(1, 0, 5, 5, 0);
        drain();
        chk("hold_v", {31'd0, bus.m_valid}, 0);
        chk("hold_d", $signed(bus.m_data), 5);

        // 2: reconstruction of 10,13,9,-4 from differences
        send(1, 1, 10, 10, 0);
        send(1, 0, 3, 13, 0);
        send(1, 0, -4, 9, 0);
        send(1, 0, -13, -4, 0);
        drain();

        // 3: four-cycle stall mid-stream
        send(1, 1, 1, 1, 0);
        send(1, 0, 1, 2, 0);
        send(1, 0, 1, 3, 0);
        @(negedge clk);
        cke = 1'b0;
        rand_in();
        bus.s_valid = 1'b1;
        #1;
        snap_v = bus.m_valid; snap_d = bus.m_data; snap_s = bus.m_sat;
        repeat (3) begin
            @(negedge clk);
            rand_in();
            bus.s_valid = 1'b1;
            #1;
            chk("stall_v", {31'd0, bus.m_valid}, {31'd0, snap_v});
            chk("stall_d", {24'd0, bus.m_data}, {24'd0, snap_d});
            chk("stall_s", {31'd0, bus.m_sat}, {31'd0, snap_s});
        end
        send(1, 0, 1, 4, 0);
        send(1, 0, 1, 5, 0);
        drain();

        // 4: clear behaviour
        send(1, 1, 1, 1, 0);
        send(1, 0, 2, 3, 0);
        send(1, 0, 3, 6, 0);
        send(1, 1, 7, 7, 0);
        send(1, 0, 1, 8, 0);
        send(0, 1, 0, 0, 0);
        send(1, 0, 4, 4, 0);
        drain();

        // 5: overflow
        send(1, 1, 127, 127, 0);
        send(1, 0, 1, SAT ? 127 : -128, SAT);
        send(1, 1, 120, 120, 0);
        send(1, 0, 10, SAT ? 127 : -126, SAT);
        send(1, 1, -100, -100, 0);
        send(1, 0, -128, SAT ? -128 : 28, SAT);
        drain();

        // 6: async reset pulse between edges
        send(1, 1, 2, 2, 0);
        send(1, 0, 3, 5, 0);
        send(1, 0, 4, 9, 0);
        @(negedge clk);
        bus.s_valid = 1'b0; bus.s_clear = 1'b0;
        #1;
        chk("pre_rst_v", {31'd0, bus.m_valid}, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_v", {31'd0, bus.m_valid}, 0);
        chk("arst_d", {24'd0, bus.m_data}, 0);
        chk("arst_s", {31'd0, bus.m_sat}, 0);
        #1;
        rst_n = 1'b1;
        q.delete();
        send(1, 0, 4, 4, 0);
        send(1, 0, 3, 7, 0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
